// File: rtl/slot_irq_ctrl.sv
// slot_irq_ctrl: collects four active-low slot IRQ lines, latches edge/level
// events, masks them onto CPU_nIRQ and offers round-robin vectoring at $4038-$403B.
module slot_irq_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  MASK_RESET  = 4'h0,
    parameter logic [3:0]  MODE_RESET  = 4'hF
) (
    input  logic        SYSCLK,
    input  logic        nRESET,
    input  logic        M2,
    input  logic        nROMSEL,
    input  logic [14:0] CPU_A,
    input  logic        CPU_RW,
    input  logic [7:0]  CPU_D_IN,
    output logic [7:0]  CPU_D_OUT,
    output logic        CPU_D_OE,
    input  logic [3:0]  SLOT_nIRQ,
    output logic        CPU_nIRQ
);

    localparam int unsigned NSLOT    = 4;
    localparam logic [12:0] REG_PAGE = 13'h100E;

    logic [SYNC_STAGES-1:0]            m2_sync;
    logic [SYNC_STAGES-1:0][NSLOT-1:0] nirq_sync;
    logic                              m2s;
    logic                              m2s_d;
    logic [NSLOT-1:0]                  nirq_s;
    logic [NSLOT-1:0]                  nirq_d;

    logic [NSLOT-1:0] irq_mask;
    logic [NSLOT-1:0] irq_mode;
    logic [NSLOT-1:0] edge_latch;
    logic [1:0]       rr_ptr;

    logic       lat_hit;
    logic       lat_rw;
    logic [1:0] lat_reg;
    logic [7:0] lat_d;
    logic [7:0] lat_vec;

    logic             commit_c;
    logic             hit_c;
    logic [NSLOT-1:0] pend_c;
    logic [NSLOT-1:0] active_c;
    logic             vec_valid_c;
    logic [1:0]       vec_slot_c;
    logic [7:0]       vec_c;
    logic [7:0]       rd_data_c;
    logic [NSLOT-1:0] edge_set_c;
    logic [NSLOT-1:0] edge_clr_c;
    logic [NSLOT-1:0] mask_nxt_c;
    logic [NSLOT-1:0] mode_nxt_c;
    logic [1:0]       rr_nxt_c;

    assign m2s      = m2_sync[SYNC_STAGES-1];
    assign nirq_s   = nirq_sync[SYNC_STAGES-1];
    assign commit_c = m2s_d & ~m2s;
    assign hit_c    = nROMSEL && (CPU_A[14:2] == REG_PAGE);
    assign pend_c   = (irq_mode & edge_latch) | (~irq_mode & ~nirq_s);
    assign active_c = pend_c & irq_mask;
    assign vec_c    = vec_valid_c ? {1'b1, 5'b0, vec_slot_c} : 8'h00;

    // Synchronise M2 and the slot IRQ lines, keep one cycle of history for edge detection
    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            m2_sync   <= '0;
            nirq_sync <= '1;
            m2s_d     <= 1'b0;
            nirq_d    <= '1;
        end else begin
            m2_sync   <= {m2_sync[SYNC_STAGES-2:0], M2};
            nirq_sync <= {nirq_sync[SYNC_STAGES-2:0], SLOT_nIRQ};
            m2s_d     <= m2s;
            nirq_d    <= nirq_s;
        end
    end

    // Round-robin pick: first active slot at or after rr_ptr, wrapping 3->0
    always_comb begin
        logic [1:0] idx;
        vec_valid_c = 1'b0;
        vec_slot_c  = 2'd0;
        idx         = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = rr_ptr + 2'(i);
            if (active_c[idx]) begin
                vec_valid_c = 1'b1;
                vec_slot_c  = idx;
            end
        end
    end

    // Live register read mux, zero outside the register window
    always_comb begin
        rd_data_c = 8'h00;
        case (CPU_A[1:0])
            2'd0:    rd_data_c = {4'h0, irq_mask};
            2'd1:    rd_data_c = {4'h0, irq_mode};
            2'd2:    rd_data_c = {|active_c, 3'b0, pend_c};
            default: rd_data_c = vec_c;
        endcase
        CPU_D_OUT = hit_c ? rd_data_c : 8'h00;
        CPU_D_OE  = M2 && CPU_RW && hit_c;
    end

    // Capture the bus (and the vector being presented) while synchronised M2 is high
    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            lat_hit <= 1'b0;
            lat_rw  <= 1'b1;
            lat_reg <= 2'd0;
            lat_d   <= 8'h00;
            lat_vec <= 8'h00;
        end else if (m2s) begin
            lat_hit <= hit_c;
            lat_rw  <= CPU_RW;
            lat_reg <= CPU_A[1:0];
            lat_d   <= CPU_D_IN;
            lat_vec <= vec_c;
        end
    end

    // Commit effects and edge detection; a new edge beats a same-cycle clear
    always_comb begin
        mask_nxt_c = irq_mask;
        mode_nxt_c = irq_mode;
        rr_nxt_c   = rr_ptr;
        edge_clr_c = '0;
        edge_set_c = irq_mode & nirq_d & ~nirq_s;
        if (commit_c && lat_hit) begin
            if (!lat_rw) begin
                case (lat_reg)
                    2'd0: mask_nxt_c = lat_d[3:0];
                    2'd1: begin
                        mode_nxt_c = lat_d[3:0];
                        edge_clr_c = irq_mode & ~lat_d[3:0];
                    end
                    2'd2:    edge_clr_c = irq_mode & lat_d[3:0];
                    default: ;
                endcase
            end else if (lat_reg == 2'd3 && lat_vec[7]) begin
                edge_clr_c[lat_vec[1:0]] = irq_mode[lat_vec[1:0]];
                rr_nxt_c                 = lat_vec[1:0] + 2'd1;
            end
        end
    end

    // Architectural state and the registered IRQ output
    always_ff @(posedge SYSCLK or negedge nRESET) begin
        if (!nRESET) begin
            irq_mask   <= MASK_RESET;
            irq_mode   <= MODE_RESET;
            edge_latch <= '0;
            rr_ptr     <= 2'd0;
            CPU_nIRQ   <= 1'b1;
        end else begin
            irq_mask   <= mask_nxt_c;
            irq_mode   <= mode_nxt_c;
            edge_latch <= (edge_latch & ~edge_clr_c) | edge_set_c;
            rr_ptr     <= rr_nxt_c;
            CPU_nIRQ   <= ~|active_c;
        end
    end

endmodule
